// File: rtl/tick_timer_pkg.sv
// Shared types and default widths for the tick_timer block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DIV_W_DEF / CNT_W_DEF : default prescaler and tick-count widths
//   state_t               : controller states (idle, counting, one-cycle expiry)
package tick_timer_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // ST_DONE is a single-cycle state whose only job is to produce the
    // done pulse. It always falls back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: emits a one-cycle tick every div+1 enabled cycles.
// Latency: tick is a combinational decode of the phase register; first tick div cycles after clearing.
// Backpressure: none; en gates advancement and clr forces the phase back to zero.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the phase (held high while the owner is counting)
//   clr        : synchronous clear of the phase; has priority over en
//   div        : divide value D, must stay stable while en is high
//   tick       : en && (phase == div)
module tick_prescaler
    import tick_timer_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] PH_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] phase;

    // Equality compare: the phase wraps to zero on the tick itself, so it
    // never has to run past div and cannot overflow while div is held.
    assign tick = en && (phase == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr || tick) begin
            phase <= '0;
        end else if (en) begin
            phase <= phase + PH_ONE;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// Programmable countdown timer: counts N prescaler ticks of period D+1 and pulses done on expiry.
// Latency: start at edge E0 -> first tick in cycle after E0+D, done in cycle after E0+N*(D+1).
// Backpressure: none; start is only accepted in IDLE, start during RUN/DONE is dropped.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : begin a countdown (only looked at in IDLE)
//   stop       : abort a running countdown; count is frozen, no done pulse
//   div_val    : prescaler divide value D, latched on start
//   load_val   : number of ticks N, loaded on start (0 expires immediately)
//   tick       : one-cycle prescaler enable while running
//   busy       : high while counting
//   count      : remaining ticks
//   done       : one-cycle expiry pulse
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_val,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic             running;
    logic             pre_clr;

    assign running = (state_q == ST_RUN);

    // The phase is held at zero whenever we are not counting, so entering
    // RUN always starts a fresh period. A stop also clears it so the next
    // run starts from a clean phase regardless of where it was aborted.
    assign pre_clr = !running || stop;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (running),
        .clr   (pre_clr),
        .div   (div_q),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A zero load is a valid request that expires at once;
                    // it still goes through ST_DONE so the caller sees done.
                    count_d = load_val;
                    div_d   = div_val;
                    state_d = (load_val != '0) ? ST_RUN : ST_DONE;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort wins over a coincident final tick: count freezes.
                    state_d = ST_IDLE;
                end else if (tick) begin
                    // count is never zero in RUN (load of zero skips RUN and
                    // we leave on the 1->0 step); guard anyway so it can
                    // never wrap.
                    if (count_q != '0) begin
                        count_d = count_q - CNT_ONE;
                    end
                    if (count_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = running;
    assign done  = (state_q == ST_DONE);
    assign count = count_q;

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [7:0]  div_val;
    logic [15:0] load_val;
    logic        tick;
    logic        busy;
    logic [15:0] count;
    logic        done;

    tick_timer #(.DIV_W(8), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .div_val  (div_val),
        .load_val (load_val),
        .tick     (tick),
        .busy     (busy),
        .count    (count),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    bit chk_on = 1'b0;
    bit busy_seen;
    int tick_q[$];
    int done_q[$];
    int exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_q(input string nm, input int g[$], input int e[$]);
        bit ok;
        ok = (g.size() == e.size());
        if (ok) begin
            for (int i = 0; i < g.size(); i++) begin
                if (g[i] != e[i]) ok = 1'b0;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%p exp=%p", nm, g, e);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks only the request (D, N), the cycles elapsed
    // since it was accepted, and a frozen count for idle periods. Outputs
    // are derived arithmetically from elapsed time.
    // m_mode: 0 idle, 1 counting, 2 expiry cycle
    // ------------------------------------------------------------------
    int m_mode, m_k, m_d, m_n, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_k <= 0; m_d <= 0; m_n <= 0; m_cnt <= 0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_d <= int'(div_val);
                    m_n <= int'(load_val);
                    m_k <= 0;
                    if (load_val == 16'd0) begin
                        m_mode <= 2;
                        m_cnt  <= 0;
                    end else begin
                        m_mode <= 1;
                    end
                end
                1: if (stop) begin
                    m_cnt  <= m_n - m_k / (m_d + 1);
                    m_mode <= 0;
                end else begin
                    m_k <= m_k + 1;
                    if (m_k + 1 == m_n * (m_d + 1)) begin
                        m_mode <= 2;
                        m_cnt  <= 0;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Compare + event log, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("busy",  int'(busy), (m_mode == 1) ? 1 : 0);
            chk("tick",  int'(tick),
                (m_mode == 1 && (m_k % (m_d + 1)) == m_d) ? 1 : 0);
            chk("count", int'(count),
                (m_mode == 1) ? (m_n - m_k / (m_d + 1)) : m_cnt);
            chk("done",  int'(done), (m_mode == 2) ? 1 : 0);
            if (tick) tick_q.push_back(cyc - e0);
            if (done) done_q.push_back(cyc - e0);
            if (busy) busy_seen = 1'b1;
        end
    end

    // Returns at the negedge of cycle k=0 (cycle after the start edge).
    task automatic pulse_start(input int d, input int n);
        @(negedge clk);
        div_val  = 8'(d);
        load_val = 16'(n);
        start    = 1'b1;
        e0       = cyc + 1;
        tick_q.delete();
        done_q.delete();
        busy_seen = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for done after %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        div_val  = 8'd0;
        load_val = 16'd0;
        busy_seen = 1'b0;

        // Reset state
        #3;
        chk("rst_busy",  int'(busy),  0);
        chk("rst_tick",  int'(tick),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_count", int'(count), 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        // D=3, N=5
        pulse_start(3, 5);
        chk("d3_count_start", int'(count), 5);
        wait_done("d3n5", 40);
        @(negedge clk);
        exp_q = '{3, 7, 11, 15, 19};
        cmp_q("d3n5_ticks", tick_q, exp_q);
        exp_q = '{20};
        cmp_q("d3n5_done", done_q, exp_q);
        chk("d3n5_busy_after",  int'(busy),  0);
        chk("d3n5_count_after", int'(count), 0);

        // D=0, N=1
        pulse_start(0, 1);
        wait_done("d0n1", 10);
        @(negedge clk);
        exp_q = '{0};
        cmp_q("d0n1_ticks", tick_q, exp_q);
        exp_q = '{1};
        cmp_q("d0n1_done", done_q, exp_q);

        // load_val = 0: immediate expiry, never busy
        pulse_start(5, 0);
        repeat (3) @(negedge clk);
        exp_q = {};
        cmp_q("n0_ticks", tick_q, exp_q);
        exp_q = '{0};
        cmp_q("n0_done", done_q, exp_q);
        chk("n0_busy_seen", int'(busy_seen), 0);

        // D=2, N=4, stop coincident with the 4th tick
        pulse_start(2, 4);
        repeat (11) @(negedge clk);
        chk("stop_on_4th_tick", int'(tick), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy",  int'(busy),  0);
        chk("stop_count", int'(count), 1);
        repeat (3) @(negedge clk);
        chk("stop_count_held", int'(count), 1);
        exp_q = '{2, 5, 8, 11};
        cmp_q("stop_ticks", tick_q, exp_q);
        exp_q = {};
        cmp_q("stop_no_done", done_q, exp_q);

        // D=1, N=3: div change + restart attempt mid-run, start during DONE
        pulse_start(1, 3);
        repeat (2) @(negedge clk);
        div_val  = 8'd7;
        load_val = 16'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("d1n3", 20);
        start    = 1'b1;
        load_val = 16'd5;
        div_val  = 8'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_in_done_busy", int'(busy), 0);
        exp_q = '{1, 3, 5};
        cmp_q("d1n3_ticks", tick_q, exp_q);
        exp_q = '{6};
        cmp_q("d1n3_done", done_q, exp_q);

        // Reset mid-count: outputs drop without a clock edge, no done
        pulse_start(2, 10);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  int'(busy),  0);
        chk("arst_tick",  int'(tick),  0);
        chk("arst_count", int'(count), 0);
        chk("arst_done",  int'(done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q = {};
        cmp_q("arst_no_done", done_q, exp_q);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
